// File: rtl/reg_dump_scanner_if.sv
// Valid/ready stream carrying {index, value} pairs from the register dump
// scanner to the display/debug unit.
interface reg_dump_scanner_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_idx;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_scanner.sv
// Debug-side register dump scanner: walks an inclusive index range over the
// register file checker port and streams each {index, value} pair out.
module reg_dump_scanner #(
    parameter int SETTLE = 1,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [4:0]          first_idx,
    input  logic [4:0]          last_idx,
    output logic [4:0]          chk_idx,
    input  logic [DATA_W-1:0]   chk_data,
    reg_dump_scanner_if.master  out_if,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SEND
    } state_t;

    localparam logic [2:0] SETTLE_INIT = 3'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [4:0]        cur_q, cur_d;
    logic [4:0]        last_q, last_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [4:0]        chk_idx_q, chk_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // NOTE: every variable gets its hold/default value before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        chk_idx_d   = chk_idx_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in the same cycle suppresses the start entirely
                if (start && !abort) begin
                    if (first_idx <= last_idx) begin
                        last_d    = last_idx;
                        cur_d     = first_idx;
                        chk_idx_d = first_idx;
                        cnt_d     = SETTLE_INIT;
                        state_d   = S_SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    out_data_d  = chk_data;
                    out_idx_d   = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
            end

            S_SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // cur stays below last here, so the increment never wraps
                        cur_d     = cur_q + 5'd1;
                        chk_idx_d = cur_q + 5'd1;
                        cnt_d     = SETTLE_INIT;
                        state_d   = S_SETTLE;
                    end
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            chk_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            chk_idx_q   <= chk_idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign chk_idx          = chk_idx_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_idx   = out_idx_q;
    assign out_if.out_data  = out_data_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Scoreboard bench for reg_dump_scanner: one instance with SETTLE=1 driven
// from a register file model, one with SETTLE=4 fed deliberately unsettled data.
module tb_reg_dump_scanner;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // SETTLE=1 instance
    logic        start, abort;
    logic [4:0]  first_idx, last_idx, chk_idx;
    logic [31:0] chk_data;
    logic        busy, done, err;
    logic [31:0] regs [32];
    reg_dump_scanner_if #(.DATA_W(32)) if1 ();

    // SETTLE=4 instance
    logic        start4, abort4;
    logic [4:0]  first4, last4, chk_idx4;
    logic [31:0] chk_data4;
    logic        busy4, done4, err4;
    reg_dump_scanner_if #(.DATA_W(32)) if4 ();

    pair_t       q1[$];
    pair_t       q4[$];
    int          gap1 = 0;
    bit          stall_en = 1'b0;
    int          done_cnt1 = 0;
    int          done_cnt4 = 0;

    reg_dump_scanner #(.SETTLE(1), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx),
        .chk_idx(chk_idx), .chk_data(chk_data), .out_if(if1),
        .busy(busy), .done(done), .err(err)
    );

    reg_dump_scanner #(.SETTLE(4), .DATA_W(32)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .first_idx(first4), .last_idx(last4),
        .chk_idx(chk_idx4), .chk_data(chk_data4), .out_if(if4),
        .busy(busy4), .done(done4), .err(err4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign chk_data = regs[chk_idx];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Consumer: ready always, or held low for the first 5 valid cycles of each pair.
    int vcnt = 0;
    always @(posedge clk) begin
        #1;
        if (if1.out_valid) vcnt++;
        else vcnt = 0;
        if1.out_ready = !stall_en || (vcnt > 5);
    end

    // Register file for the SETTLE=4 instance: data is junk for the first three
    // cycles after the index changes, then settles to 0xC0DE0000 | idx.
    int         age4 = 0;
    logic [4:0] prev4 = '0;
    always @(posedge clk) begin
        #1;
        if (chk_idx4 != prev4) age4 = 0;
        else if (age4 < 100) age4++;
        prev4 = chk_idx4;
        chk_data4 = (age4 >= 3) ? (32'hC0DE_0000 | 32'(chk_idx4)) : (32'hBAD0_0000 | 32'(age4));
    end

    // Monitor for the SETTLE=1 instance.
    bit          held1 = 1'b0;
    logic [4:0]  h_idx, h_chk;
    logic [31:0] h_data;
    int          last_hs1 = -1;
    always @(negedge clk) begin
        pair_t e;
        if (!rst) begin
            if (held1 && if1.out_valid) begin
                check("stall_idx", if1.out_idx, h_idx);
                check("stall_data", if1.out_data, h_data);
                check("stall_chk_idx", chk_idx, h_chk);
            end
            held1  = if1.out_valid && !if1.out_ready;
            h_idx  = if1.out_idx;
            h_data = if1.out_data;
            h_chk  = chk_idx;
            if (!busy) last_hs1 = -1;
            if (if1.out_valid && if1.out_ready) begin
                if (q1.size() == 0) check("extra_pair", if1.out_idx, 5'h1f ^ if1.out_idx);
                else begin
                    e = q1.pop_front();
                    check("pair_idx", if1.out_idx, e.idx);
                    check("pair_data", if1.out_data, e.data);
                end
                if (gap1 != 0 && last_hs1 >= 0) check("pair_gap", cyc - last_hs1, gap1);
                last_hs1 = cyc;
            end
            if (done) begin
                done_cnt1++;
                check("busy_at_done", busy, 0);
                check("err_at_done", err, 0);
            end
        end
    end

    // Monitor for the SETTLE=4 instance.
    int last_hs4 = -1;
    always @(negedge clk) begin
        pair_t e;
        if (!rst) begin
            if (!busy4) last_hs4 = -1;
            if (if4.out_valid && if4.out_ready) begin
                if (q4.size() == 0) check("extra_pair4", if4.out_idx, 5'h1f ^ if4.out_idx);
                else begin
                    e = q4.pop_front();
                    check("pair4_idx", if4.out_idx, e.idx);
                    check("pair4_data", if4.out_data, e.data);
                end
                if (last_hs4 >= 0) check("pair4_gap", cyc - last_hs4, 5);
                last_hs4 = cyc;
            end
            if (done4) done_cnt4++;
        end
    end

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++) q1.push_back('{idx: 5'(i), data: regs[i]});
    endtask

    task automatic launch(input logic [4:0] f, input logic [4:0] l);
        @(posedge clk); #1;
        first_idx = f; last_idx = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_chk_idx", chk_idx, f);
        check("start_busy", busy, 1);
        // range inputs change mid-scan; the latched range must win
        first_idx = 5'd0; last_idx = 5'd0;
    endtask

    task automatic wait_done1;
        bit seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic scan1(input int f, input int l, input int gap);
        int d0;
        d0   = done_cnt1;
        gap1 = gap;
        push_range(f, l);
        launch(5'(f), 5'(l));
        @(posedge clk); #1;
        check("first_valid", if1.out_valid, 1);
        check("first_out_idx", if1.out_idx, 5'(f));
        wait_done1();
        @(posedge clk); #1;
        check("done_count", done_cnt1 - d0, 1);
        check("queue_empty", q1.size(), 0);
        check("idle_busy", busy, 0);
        check("done_pulse", done, 0);
        gap1 = 0;
    endtask

    task automatic wait_hs_idx(input logic [4:0] idx);
        bit seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (if1.out_valid && if1.out_ready && if1.out_idx == idx) seen = 1'b1;
        end
        if (!seen) check("hs_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; first_idx = '0; last_idx = '0;
        start4 = 1'b0; abort4 = 1'b0; first4 = '0; last4 = '0;
        if4.out_ready = 1'b1;
        regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h10 + 32'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_chk_idx", chk_idx, 0);
        check("rst_out_valid", if1.out_valid, 0);
        check("rst_out_idx", if1.out_idx, 0);
        check("rst_out_data", if1.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // full dump, one pair every 2 cycles
        scan1(1, 31, 2);

        // single register, then index 0
        regs[5] = 32'hDEAD_BEEF;
        scan1(5, 5, 0);
        scan1(0, 0, 0);

        // backpressure
        stall_en = 1'b1;
        scan1(2, 4, 0);
        stall_en = 1'b0;

        // invalid range
        d0 = done_cnt1;
        @(posedge clk); #1;
        first_idx = 5'd9; last_idx = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_valid", if1.out_valid, 0);
        @(posedge clk); #1;
        check("bad_err_pulse", err, 0);
        check("bad_busy_after", busy, 0);
        check("bad_no_done", done_cnt1 - d0, 0);
        scan1(3, 9, 2);

        // abort together with start in IDLE
        @(posedge clk); #1;
        first_idx = 5'd1; last_idx = 5'd4; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_err", err, 0);

        // abort after pair 10 is accepted
        d0 = done_cnt1;
        push_range(1, 10);
        launch(5'd1, 5'd31);
        wait_hs_idx(5'd10);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", if1.out_valid, 0);
        check("abort_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt1 - d0, 0);
        check("abort_queue", q1.size(), 0);
        scan1(1, 2, 2);

        // asynchronous reset mid-scan
        d0 = done_cnt1;
        push_range(1, 5);
        launch(5'd1, 5'd31);
        wait_hs_idx(5'd5);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_chk_idx", chk_idx, 0);
        check("arst_valid", if1.out_valid, 0);
        check("arst_out_idx", if1.out_idx, 0);
        check("arst_out_data", if1.out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_done", done_cnt1 - d0, 0);
        check("arst_queue", q1.size(), 0);
        scan1(1, 2, 2);

        // SETTLE=4: captured value is the settled one, a pair every 5 cycles
        for (int i = 7; i <= 9; i++) q4.push_back('{idx: 5'(i), data: 32'hC0DE_0000 | 32'(i)});
        @(posedge clk); #1;
        first4 = 5'd7; last4 = 5'd9; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("s4_chk_idx", chk_idx4, 7);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                if (done4) seen = 1'b1;
            end
            if (!seen) check("done4_timeout", 0, 1);
        end
        @(posedge clk); #1;
        check("s4_done_count", done_cnt4, 1);
        check("s4_queue", q4.size(), 0);
        check("s4_busy", busy4, 0);
        check("s4_err", err4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
